// File: rtl/eh2_posit_mul_pipe.sv
// Two-stage posit multiplier core: S1 captures the operands and the hidden-bit
// mantissa product; S2 holds the normalised fraction, summed scale and special flags.
module eh2_posit_mul_pipe #(
    parameter int POSIT_LEN   = 16,
    parameter int ES          = 2,
    parameter int REGIME_BW   = $clog2(POSIT_LEN),
    parameter int FRACTION_BW = POSIT_LEN - ES - 3,
    parameter int PRODUCT_FRA = 2 * (FRACTION_BW + 1),
    parameter int FRAC_W_GRS  = POSIT_LEN - ES,
    parameter int MAX_REG     = POSIT_LEN - 1
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        a_sgn,
    input  logic signed [REGIME_BW-1:0] a_reg,
    input  logic [ES-1:0]               a_exp,
    input  logic [FRACTION_BW-1:0]      a_fra,
    input  logic                        a_zero,
    input  logic                        a_nar,
    input  logic                        b_sgn,
    input  logic signed [REGIME_BW-1:0] b_reg,
    input  logic [ES-1:0]               b_exp,
    input  logic [FRACTION_BW-1:0]      b_fra,
    input  logic                        b_zero,
    input  logic                        b_nar,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        product_sgn,
    output logic [REGIME_BW-1:0]        product_reg,
    output logic [ES-1:0]               product_exp,
    output logic [FRAC_W_GRS-1:0]       product_fra,
    output logic                        product_zero,
    output logic                        product_nar,
    output logic                        is_oflw_or_uflw
);

    localparam int SUM_W    = REGIME_BW + ES + 1;
    localparam int STK_HI_W = PRODUCT_FRA - FRAC_W_GRS;
    localparam int STK_LO_W = STK_HI_W - 1;
    localparam logic signed [SUM_W-1:0] MAX_REG_S = SUM_W'(MAX_REG);

    // Handshake / valid tracking
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_advance, s2_advance, in_fire;

    assign s2_advance = s2_valid_q & out_ready;
    assign s1_advance = s1_valid_q & (~s2_valid_q | s2_advance);
    assign in_ready   = ~s1_valid_q | s1_advance;
    assign in_fire    = in_valid & in_ready;

    assign s1_valid_d = flush ? 1'b0 : (in_fire | (s1_valid_q & ~s1_advance));
    assign s2_valid_d = flush ? 1'b0 : (s1_advance | (s2_valid_q & ~s2_advance));

    // Stage 1 data
    logic                        s1_sgn_q, s1_zero_q, s1_nar_q;
    logic signed [REGIME_BW-1:0] s1_a_reg_q, s1_b_reg_q;
    logic [ES-1:0]               s1_a_exp_q, s1_b_exp_q;
    logic [PRODUCT_FRA-1:0]      s1_prod_q, s1_prod_d;
    logic [FRACTION_BW:0]        mant_a, mant_b;

    assign mant_a    = {1'b1, a_fra};
    assign mant_b    = {1'b1, b_fra};
    assign s1_prod_d = PRODUCT_FRA'(mant_a) * PRODUCT_FRA'(mant_b);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s1_valid_q <= 1'b0;
            s1_sgn_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_nar_q   <= 1'b0;
            s1_a_reg_q <= '0;
            s1_b_reg_q <= '0;
            s1_a_exp_q <= '0;
            s1_b_exp_q <= '0;
            s1_prod_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_fire) begin
                s1_sgn_q   <= a_sgn ^ b_sgn;
                s1_zero_q  <= a_zero | b_zero;
                s1_nar_q   <= a_nar | b_nar;
                s1_a_reg_q <= a_reg;
                s1_b_reg_q <= b_reg;
                s1_a_exp_q <= a_exp;
                s1_b_exp_q <= b_exp;
                s1_prod_q  <= s1_prod_d;
            end
        end
    end

    // Scale is {regime, exponent} as one signed number; product MSB adds one.
    logic signed [SUM_W-1:0]  scale_a, scale_b, sum, temp;
    logic                     prod_msb;
    logic [FRAC_W_GRS-2:0]    fra_hi, fra_lo;
    logic                     sticky_hi, sticky_lo;

    assign prod_msb  = s1_prod_q[PRODUCT_FRA-1];
    assign scale_a   = {s1_a_reg_q[REGIME_BW-1], s1_a_reg_q, s1_a_exp_q};
    assign scale_b   = {s1_b_reg_q[REGIME_BW-1], s1_b_reg_q, s1_b_exp_q};
    assign sum       = scale_a + scale_b + {{(SUM_W-1){1'b0}}, prod_msb};
    assign temp      = sum >>> ES;
    assign fra_hi    = s1_prod_q[PRODUCT_FRA-2 -: FRAC_W_GRS-1];
    assign fra_lo    = s1_prod_q[PRODUCT_FRA-3 -: FRAC_W_GRS-1];
    assign sticky_hi = |s1_prod_q[STK_HI_W-1:0];
    assign sticky_lo = |s1_prod_q[STK_LO_W-1:0];

    logic                  res_sgn_d, res_zero_d, res_nar_d, res_flag_d;
    logic [REGIME_BW-1:0]  res_reg_d;
    logic [ES-1:0]         res_exp_d;
    logic [FRAC_W_GRS-1:0] res_fra_d;

    always_comb begin
        res_sgn_d  = 1'b0;
        res_zero_d = 1'b0;
        res_nar_d  = 1'b0;
        res_flag_d = 1'b0;
        res_reg_d  = '0;
        res_exp_d  = '0;
        res_fra_d  = '0;
        if (s1_nar_q) begin
            res_nar_d = 1'b1;
        end else if (s1_zero_q) begin
            res_zero_d = 1'b1;
        end else begin
            res_sgn_d  = s1_sgn_q;
            res_reg_d  = temp[REGIME_BW-1:0];
            res_exp_d  = sum[ES-1:0];
            res_fra_d  = prod_msb ? {fra_hi, sticky_hi} : {fra_lo, sticky_lo};
            res_flag_d = (temp >= MAX_REG_S) | (-temp > MAX_REG_S);
        end
    end

    // Stage 2 registers drive the outputs directly
    logic                  s2_sgn_q, s2_zero_q, s2_nar_q, s2_flag_q;
    logic [REGIME_BW-1:0]  s2_reg_q;
    logic [ES-1:0]         s2_exp_q;
    logic [FRAC_W_GRS-1:0] s2_fra_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            s2_valid_q <= 1'b0;
            s2_sgn_q   <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_nar_q   <= 1'b0;
            s2_flag_q  <= 1'b0;
            s2_reg_q   <= '0;
            s2_exp_q   <= '0;
            s2_fra_q   <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s1_advance) begin
                s2_sgn_q  <= res_sgn_d;
                s2_zero_q <= res_zero_d;
                s2_nar_q  <= res_nar_d;
                s2_flag_q <= res_flag_d;
                s2_reg_q  <= res_reg_d;
                s2_exp_q  <= res_exp_d;
                s2_fra_q  <= res_fra_d;
            end
        end
    end

    assign out_valid       = s2_valid_q;
    assign product_sgn     = s2_sgn_q;
    assign product_reg     = s2_reg_q;
    assign product_exp     = s2_exp_q;
    assign product_fra     = s2_fra_q;
    assign product_zero    = s2_zero_q;
    assign product_nar     = s2_nar_q;
    assign is_oflw_or_uflw = s2_flag_q;

endmodule

// File: doc/eh2_posit_mul_pipe.md
EH2_POSIT_MUL_PIPE -- requirements
Module: eh2_posit_mul_pipe

Interface
REQ-001 The block SHALL have parameter POSIT_LEN, default 16, meaning the posit word width.
REQ-002 The block SHALL have parameter ES, default 2, meaning the exponent field width.
REQ-003 The block SHALL have these derived parameters: REGIME_BW = $clog2(POSIT_LEN); FRACTION_BW = POSIT_LEN-ES-3; PRODUCT_FRA = 2*(FRACTION_BW+1); FRAC_W_GRS = POSIT_LEN-ES; MAX_REG = POSIT_LEN-1.
REQ-004 clk  in  1  the single clock.
REQ-005 rst_l  in  1  the reset, asynchronous and active-low.
REQ-006 flush  in  1  kills all in-flight operations.
REQ-007 in_valid  in  1 / in_ready  out  1  are the input handshake.
REQ-008 a_sgn  in  1; a_reg  in  REGIME_BW (signed); a_exp  in  ES; a_fra  in  FRACTION_BW; a_zero  in  1; a_nar  in  1  form operand A.
REQ-009 b_sgn, b_reg, b_exp, b_fra, b_zero, b_nar form operand B, with the same widths as operand A.
REQ-010 out_valid  out  1 / out_ready  in  1  are the output handshake.
REQ-011 product_sgn  out  1; product_reg  out  REGIME_BW; product_exp  out  ES; product_fra  out  FRAC_W_GRS; product_zero  out  1; product_nar  out  1; is_oflw_or_uflw  out  1  form the result.

Function
REQ-012 The block SHALL be a 2-stage pipeline: S1 registers the operands and the unsigned product {1,a_fra}*{1,b_fra} (PRODUCT_FRA bits); S2 registers the normalized, scale-summed result.
REQ-013 Latency SHALL be 2 cycles from input handshake to out_valid when out_ready is held high; throughput SHALL be 1 op/cycle.
REQ-014 Each stage SHALL hold a valid bit; a stage advances when its successor is empty or is advancing in the same cycle.
REQ-015 in_ready SHALL be !s1_valid | s1_advance, computed combinationally with no dependence on in_valid.
REQ-016 out_valid and all result outputs SHALL be driven directly from S2 registers and SHALL hold stable while out_valid & !out_ready.
REQ-017 Results SHALL leave in issue order, with no drop and no duplication under any backpressure pattern.
REQ-018 Scale SHALL equal {reg,exp} signed per operand; sum = scaleA + scaleB + prod[PRODUCT_FRA-1], computed at REGIME_BW+ES+1 bits; product_exp = sum[ES-1:0]; temp = sum >>> ES; product_reg = temp[REGIME_BW-1:0].
REQ-019 is_oflw_or_uflw SHALL equal (temp >= MAX_REG) | (-temp > MAX_REG), with both comparisons signed.
REQ-020 If prod MSB = 1, product_fra[FRAC_W_GRS-1:1] SHALL be prod[PRODUCT_FRA-2 -: FRAC_W_GRS-1]; otherwise it SHALL be prod[PRODUCT_FRA-3 -: FRAC_W_GRS-1].
REQ-021 product_fra[0] (sticky) SHALL be the OR of ALL prod bits below the selected field.
REQ-022 product_sgn SHALL be a_sgn ^ b_sgn.
REQ-023 If a_nar | b_nar, then product_nar = 1, product_zero = 0, and all other result fields and the flag = 0.
REQ-024 Else if a_zero | b_zero, then product_zero = 1, and all other result fields and the flag = 0.
REQ-025 NaR SHALL take precedence over zero.
REQ-026 flush SHALL clear both stage valid bits on the next edge; an input accepted in the flush cycle SHALL be discarded; out_valid SHALL be 0 the cycle after flush.
REQ-027 When flush and a handshake occur simultaneously, flush SHALL win.
REQ-028 Input fields SHALL be sampled only on in_valid & in_ready.

Reset
REQ-029 When rst_l = 0, both valid bits SHALL clear asynchronously and out_valid SHALL be 0.
REQ-030 When rst_l = 0, all data registers SHALL be 0, giving product_* = 0 and is_oflw_or_uflw = 0.
REQ-031 in_ready SHALL be 1 during and after reset.
REQ-032 An operation in flight when reset asserts SHALL be lost and SHALL never appear at the output.
REQ-033 Reset deassertion SHALL be sampled synchronously to clk.

Verification
REQ-034 1.0*1.0 (reg=0, exp=0, fra=0 on both, out_ready=1) -> out_valid 2 cycles later, with product_reg=0, product_exp=0, product_fra=0, flag=0.
REQ-035 1.5*1.5 (fra=11'h400 on both, POSIT_LEN=16) -> product_exp=1, product_reg=0, product_fra=14'h0800, sticky=0.
REQ-036 Overflow case: reg=7, exp=3 on both -> temp=15, is_oflw_or_uflw=1.
REQ-037 Underflow case: reg=-8, exp=0 on both -> is_oflw_or_uflw=1.
REQ-038 Backpressure case: issue 4 back-to-back ops with out_ready=0 for 5 cycles -> in_ready drops after 2 are accepted, outputs stay stable, and all 4 results emerge in order once out_ready rises.
REQ-039 Flush case: assert flush with 2 ops in flight -> out_valid=0 next cycle, and neither op appears later.
REQ-040 Special-value case: a_nar=1 with b_zero=1 -> product_nar=1, product_zero=0.
REQ-041 Reset case: drop rst_l mid-stream -> out_valid falls immediately (asynchronously), and no stale result appears after reset is released.
